// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-channel round-robin arbiter and its requester
// agent: channel count, encoded grant values and a grant decoder.
package rr_arb_pkg;

    localparam int NCH = 4;

    // Encoded grant: 0 means no grant, 1..4 select channel 0..3.
    localparam logic [3:0] GNT_NONE = 4'd0;
    localparam logic [3:0] GNT_CH0  = 4'd1;
    localparam logic [3:0] GNT_CH1  = 4'd2;
    localparam logic [3:0] GNT_CH2  = 4'd3;
    localparam logic [3:0] GNT_CH3  = 4'd4;

    // Encoded grant to one-hot channel select; codes outside 1..4 give zero.
    function automatic logic [NCH-1:0] gnt_to_onehot(input logic [3:0] gnt);
        logic [NCH-1:0] oh;
        oh = '0;
        case (gnt)
            GNT_CH0: oh = 4'b0001;
            GNT_CH1: oh = 4'b0010;
            GNT_CH2: oh = 4'b0100;
            GNT_CH3: oh = 4'b1000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rr_req_chan.sv
// One requester channel: pending-beat counter, load handshake and the REQ
// term presented to the arbiter.
module rr_req_chan
    import rr_arb_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             load_valid,
    input  logic [LEN_W-1:0] load_len,
    input  logic             hit,
    output logic             load_ready,
    output logic             busy,
    output logic             last,
    output logic             req
);

    logic [LEN_W-1:0] pending;

    // Load handshake: a load transfers on a cycle where load_valid and
    // load_ready are both high; load_ready is high only while the channel is
    // idle, so a busy channel stalls the loader until its burst drains.
    assign busy       = (pending != '0);
    assign last       = (pending == LEN_W'(1));
    assign load_ready = !busy;

    // Drop REQ in the cycle the final beat is taken so the registered arbiter
    // never grants this channel once it has emptied.
    assign req = busy && !(hit && last);

    // Counter: load when idle, count down once per taken beat. The two cannot
    // coincide because a hit needs a non-zero count and a load needs zero.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pending <= '0;
        end else if (load_valid && load_ready) begin
            pending <= load_len;
        end else if (hit) begin
            pending <= pending - LEN_W'(1);
        end
    end

endmodule

// File: rtl/rr_req_agent.sv
// Requester agent for the 4-channel round-robin arbiter: holds a burst per
// channel, raises REQ, consumes encoded GRANT and issues one registered beat
// per usable grant on a shared output port. Flags unusable grants.
module rr_req_agent
    import rr_arb_pkg::*;
#(
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NCH-1:0]        load_valid,
    input  logic [NCH*LEN_W-1:0]  load_len,
    output logic [NCH-1:0]        load_ready,
    input  logic [NCH*DATA_W-1:0] ch_data,
    input  logic [3:0]            GRANT,
    output logic [NCH-1:0]        REQ,
    output logic                  out_valid,
    output logic [1:0]            out_ch,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    output logic                  err_spurious
);

    logic [NCH-1:0]    gnt_oh;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    last;
    logic [NCH-1:0]    hit;
    logic              bad_code;
    logic              spurious;

    logic              hit_any;
    logic [1:0]        hit_ch;
    logic [DATA_W-1:0] hit_data;
    logic              hit_last;

    // A grant is usable only when it names a channel that has beats left.
    assign gnt_oh   = gnt_to_onehot(GRANT);
    assign hit      = gnt_oh & busy;
    assign bad_code = (GRANT > GNT_CH3);
    assign spurious = bad_code || ((gnt_oh & ~busy) != '0);

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            rr_req_chan #(.LEN_W(LEN_W)) u_chan (
                .clk        (clk),
                .RST        (RST),
                .load_valid (load_valid[g]),
                .load_len   (load_len[g*LEN_W +: LEN_W]),
                .hit        (hit[g]),
                .load_ready (load_ready[g]),
                .busy       (busy[g]),
                .last       (last[g]),
                .req        (REQ[g])
            );
        end
    endgenerate

    // Select the beat for the granted channel (at most one hit per cycle).
    always_comb begin
        hit_any  = 1'b0;
        hit_ch   = 2'd0;
        hit_data = '0;
        hit_last = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (hit[i]) begin
                hit_any  = 1'b1;
                hit_ch   = 2'(i);
                hit_data = ch_data[i*DATA_W +: DATA_W];
                hit_last = last[i];
            end
        end
    end

    // Output register: present the taken beat next cycle; hold payload otherwise.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            out_valid <= 1'b0;
            out_ch    <= 2'd0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            out_valid <= hit_any;
            if (hit_any) begin
                out_ch   <= hit_ch;
                out_data <= hit_data;
                out_last <= hit_last;
            end
        end
    end

    // Sticky error flag for grants that cannot be serviced.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            err_spurious <= 1'b0;
        end else if (spurious) begin
            err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rr_req_agent.sv
// Bench for rr_req_agent with a registered round-robin arbiter model closing
// the REQ/GRANT loop and a scoreboard of expected beats.
module tb_rr_req_agent;

    localparam int LEN_W  = 4;
    localparam int DATA_W = 8;
    localparam int NCH    = 4;
    localparam int W      = 2 + 1 + DATA_W;

    logic                  clk = 1'b0;
    logic                  RST = 1'b1;
    logic [NCH-1:0]        load_valid = '0;
    logic [NCH*LEN_W-1:0]  load_len = '0;
    logic [NCH-1:0]        load_ready;
    logic [NCH*DATA_W-1:0] ch_data = '0;
    logic [3:0]            GRANT;
    logic [NCH-1:0]        REQ;
    logic                  out_valid;
    logic [1:0]            out_ch;
    logic [DATA_W-1:0]     out_data;
    logic                  out_last;
    logic                  err_spurious;

    logic                  arb_en = 1'b1;
    logic [3:0]            force_grant = 4'd0;
    logic [3:0]            arb_grant;
    logic [1:0]            arb_last;

    int vectors     = 0;
    int miscompares = 0;
    int beats_seen  = 0;
    logic [W-1:0] exp_q[$];

    rr_req_agent #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .RST          (RST),
        .load_valid   (load_valid),
        .load_len     (load_len),
        .load_ready   (load_ready),
        .ch_data      (ch_data),
        .GRANT        (GRANT),
        .REQ          (REQ),
        .out_valid    (out_valid),
        .out_ch       (out_ch),
        .out_data     (out_data),
        .out_last     (out_last),
        .err_spurious (err_spurious)
    );

    // ---------------- clock / reset / arbiter model ----------------
    always #5 clk = ~clk;

    assign GRANT = arb_en ? arb_grant : force_grant;

    // Registered round-robin arbiter: search starts after the last winner.
    always @(posedge clk or posedge RST) begin
        if (RST) begin
            arb_grant <= 4'd0;
            arb_last  <= 2'd3;
        end else begin
            logic found;
            logic [1:0] idx;
            found = 1'b0;
            arb_grant <= 4'd0;
            for (int k = 1; k <= NCH; k++) begin
                idx = 2'(arb_last + 2'(k));
                if (!found && REQ[idx]) begin
                    found = 1'b1;
                    arb_grant <= 4'(idx) + 4'd1;
                    arb_last  <= idx;
                end
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!RST && out_valid) begin
            logic [W-1:0] exp_beat;
            vectors++;
            beats_seen++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat_unexpected: got ch=%0d last=%0b data=%0h, required no beat",
                         out_ch, out_last, out_data);
            end else begin
                exp_beat = exp_q.pop_front();
                if ({out_ch, out_last, out_data} !== exp_beat) begin
                    miscompares++;
                    $display("FAIL beat: got ch=%0d last=%0b data=%0h, required ch=%0d last=%0b data=%0h",
                             out_ch, out_last, out_data,
                             exp_beat[W-1 -: 2], exp_beat[DATA_W], exp_beat[DATA_W-1:0]);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        load_valid = '0;
        arb_en = 1'b1;
        force_grant = 4'd0;
        step();
        RST = 1'b0;
        exp_q.delete();
        beats_seen = 0;
        step();
    endtask

    task automatic set_len(input int ch, input int len);
        load_len[ch*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    function automatic logic [DATA_W-1:0] data_of(input int ch);
        return ch_data[ch*DATA_W +: DATA_W];
    endfunction

    task automatic push_beat(input int ch, input bit last_b);
        exp_q.push_back({2'(ch), last_b, data_of(ch)});
    endtask

    task automatic wait_beats(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (beats_seen < target && k < budget) begin
            step();
            k++;
        end
        vectors++;
        if (beats_seen < target) begin
            miscompares++;
            $display("FAIL %s_timeout: got %0d beats, required %0d", name, beats_seen, target);
        end
    endtask

    task automatic randomize_data();
        for (int c = 0; c < NCH; c++)
            ch_data[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 255));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1;
        #3;
        vectors++;
        if ({out_valid, out_ch, out_data, out_last, err_spurious} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%0b ch=%0d d=%0h l=%0b e=%0b, required all 0",
                     out_valid, out_ch, out_data, out_last, err_spurious);
        end
        vectors++;
        if (REQ !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_req: got %0h required 0", REQ);
        end
        vectors++;
        if (load_ready !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_load_ready: got %0h required f", load_ready);
        end
        do_reset();
    endtask

    task automatic test_single_burst();
        do_reset();
        randomize_data();
        set_len(1, 3);
        load_valid = 4'b0010;
        push_beat(1, 1'b0);
        push_beat(1, 1'b0);
        push_beat(1, 1'b1);
        step();                         // now cycle n+1
        load_valid = '0;
        vectors++;
        if (REQ !== 4'b0010 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_req_rise: got req=%0h v=%0b required req=2 v=0", REQ, out_valid);
        end
        step();                         // n+2: grant present, beat taken
        vectors++;
        if (GRANT !== 4'd2 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: got grant=%0d v=%0b required grant=2 v=0", GRANT, out_valid);
        end
        step();                         // n+3: first beat visible
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_first_beat: got v=%0b required 1", out_valid);
        end
        step();                         // n+4: third beat being taken
        vectors++;
        if (out_valid !== 1'b1 || REQ[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_req_drop: got v=%0b req1=%0b required v=1 req1=0", out_valid, REQ[1]);
        end
        step();                         // n+5: last beat visible
        vectors++;
        if (out_valid !== 1'b1 || out_last !== 1'b1) begin
            miscompares++;
            $display("FAIL single_last: got v=%0b last=%0b required 1 1", out_valid, out_last);
        end
        step();                         // n+6: idle again
        vectors++;
        if (out_valid !== 1'b0 || load_ready !== 4'hF || err_spurious !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL single_end: got v=%0b ready=%0h err=%0b left=%0d required 0 f 0 0",
                     out_valid, load_ready, err_spurious, exp_q.size());
        end
    endtask

    task automatic test_all_channels();
        do_reset();
        randomize_data();
        for (int c = 0; c < NCH; c++) set_len(c, 2);
        load_valid = 4'hF;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NCH; c++) push_beat(c, r == 1);
        step();
        load_valid = '0;
        wait_beats(8, 20, "all_beats");
        step();
        step();
        vectors++;
        if (beats_seen != 8 || load_ready !== 4'hF || REQ !== 4'h0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL all_end: got beats=%0d ready=%0h req=%0h left=%0d required 8 f 0 0",
                     beats_seen, load_ready, REQ, exp_q.size());
        end
    endtask

    task automatic test_spurious_idle_grant();
        do_reset();
        arb_en = 1'b0;
        force_grant = 4'd2;
        step();
        force_grant = 4'd0;
        vectors++;
        if (out_valid !== 1'b0 || err_spurious !== 1'b1 || load_ready !== 4'hF || REQ !== 4'h0) begin
            miscompares++;
            $display("FAIL spur_idle: got v=%0b err=%0b ready=%0h req=%0h required 0 1 f 0",
                     out_valid, err_spurious, load_ready, REQ);
        end
        for (int k = 0; k < 5; k++) step();
        vectors++;
        if (err_spurious !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_sticky: got %0b required 1", err_spurious);
        end
        do_reset();
        vectors++;
        if (err_spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_clear: got %0b required 0", err_spurious);
        end
    endtask

    task automatic test_spurious_bad_code();
        do_reset();
        randomize_data();
        arb_en = 1'b0;
        set_len(0, 2);
        load_valid = 4'b0001;
        step();
        load_valid = '0;
        force_grant = 4'd7;
        step();
        force_grant = 4'd0;
        vectors++;
        if (err_spurious !== 1'b1 || out_valid !== 1'b0 || REQ !== 4'b0001 || load_ready !== 4'b1110) begin
            miscompares++;
            $display("FAIL spur_code: got err=%0b v=%0b req=%0h ready=%0h required 1 0 1 e",
                     err_spurious, out_valid, REQ, load_ready);
        end
        // Counter untouched: both beats still come out once grants resume.
        push_beat(0, 1'b0);
        push_beat(0, 1'b1);
        arb_en = 1'b1;
        wait_beats(2, 20, "spur_code_beats");
        step();
        vectors++;
        if (load_ready !== 4'hF || err_spurious !== 1'b1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL spur_code_end: got ready=%0h err=%0b left=%0d required f 1 0",
                     load_ready, err_spurious, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        randomize_data();
        set_len(0, 5);
        load_valid = 4'b0001;
        for (int k = 0; k < 5; k++) push_beat(0, k == 4);
        step();
        load_valid = '0;
        wait_beats(2, 20, "midrst_beats");
        RST = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || REQ !== 4'h0 || load_ready !== 4'hF) begin
            miscompares++;
            $display("FAIL midrst_async: got v=%0b req=%0h ready=%0h required 0 0 f",
                     out_valid, REQ, load_ready);
        end
        exp_q.delete();
        step();
        RST = 1'b0;
        for (int k = 0; k < 12; k++) step();
        vectors++;
        if (beats_seen != 2 || load_ready !== 4'hF) begin
            miscompares++;
            $display("FAIL midrst_after: got beats=%0d ready=%0h required 2 f", beats_seen, load_ready);
        end
    endtask

    task automatic test_load_while_busy();
        do_reset();
        randomize_data();
        set_len(3, 4);
        load_valid = 4'b1000;
        for (int k = 0; k < 4; k++) push_beat(3, k == 3);
        step();
        load_valid = '0;
        wait_beats(2, 20, "busy_first");
        set_len(3, 4);
        load_valid = 4'b1000;
        vectors++;
        if (load_ready[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ready: got %0b required 0", load_ready[3]);
        end
        step();
        load_valid = '0;
        wait_beats(4, 20, "busy_rest");
        for (int k = 0; k < 6; k++) step();
        vectors++;
        if (beats_seen != 4 || load_ready !== 4'hF || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL busy_end: got beats=%0d ready=%0h left=%0d required 4 f 0",
                     beats_seen, load_ready, exp_q.size());
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_burst();
        test_all_channels();
        test_spurious_idle_grant();
        test_spurious_bad_code();
        test_reset_mid_burst();
        test_load_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
